// File: rtl/bin2bcd_serial.sv
// Serial shift-and-add-3 binary-to-BCD converter with START/BUSY/DONE handshake.
// Inputs above 10^DIGITS-1 are clamped and flagged; the result is held between completions.
module bin2bcd_serial #(
    parameter int unsigned BIN_WIDTH = 14,
    parameter int unsigned DIGITS    = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [BIN_WIDTH-1:0]  BIN_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD_OUT,
    output logic                  OVERFLOW
);

    localparam int unsigned BCD_W   = 4 * DIGITS;
    localparam int unsigned CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam int unsigned MAX_DEC = 10 ** DIGITS - 1;
    localparam logic [BIN_WIDTH-1:0] MAX_BIN   = BIN_WIDTH'(MAX_DEC);
    localparam logic [CNT_W-1:0]     LAST_ITER = CNT_W'(BIN_WIDTH - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t               state_q, state_n;
    logic [BIN_WIDTH-1:0] bin_q, bin_n;
    logic [BCD_W-1:0]     bcd_q, bcd_n, bcd_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 clamp_q, clamp_n;
    logic [BCD_W-1:0]     bcd_out_n;
    logic                 ovf_n;
    logic                 done_n;
    logic                 busy_n;

    // Add 3 to every digit that is 5 or more; digits are independent.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state_q;
        bin_n     = bin_q;
        bcd_n     = bcd_q;
        cnt_n     = cnt_q;
        clamp_n   = clamp_q;
        bcd_out_n = BCD_OUT;
        ovf_n     = OVERFLOW;
        done_n    = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    clamp_n = (BIN_IN > MAX_BIN);
                    bin_n   = clamp_n ? MAX_BIN : BIN_IN;
                    bcd_n   = '0;
                    cnt_n   = '0;
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                bcd_n = {bcd_adj[BCD_W-2:0], bin_q[BIN_WIDTH-1]};
                bin_n = {bin_q[BIN_WIDTH-2:0], 1'b0};
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    bcd_out_n = bcd_n;
                    ovf_n     = clamp_q;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == CONVERT);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            clamp_q  <= 1'b0;
            BCD_OUT  <= '0;
            OVERFLOW <= 1'b0;
            DONE     <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state_q  <= state_n;
            bin_q    <= bin_n;
            bcd_q    <= bcd_n;
            cnt_q    <= cnt_n;
            clamp_q  <= clamp_n;
            BCD_OUT  <= bcd_out_n;
            OVERFLOW <= ovf_n;
            DONE     <= done_n;
            BUSY     <= busy_n;
        end
    end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Scoreboard bench for bin2bcd_serial: expected results queued at START, checked on DONE.
module tb_bin2bcd_serial;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin_in = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    int tests = 0;
    int fails = 0;
    logic [16:0] sb[$];

    bin2bcd_serial #(.BIN_WIDTH(14), .DIGITS(4)) dut (
        .CLK      (clk),
        .RESET    (reset),
        .START    (start),
        .BIN_IN   (bin_in),
        .BUSY     (busy),
        .DONE     (done),
        .BCD_OUT  (bcd_out),
        .OVERFLOW (overflow)
    );

    always #5 clk = ~clk;

    // Decimal-arithmetic reference: {overflow, d3, d2, d1, d0}.
    function automatic logic [16:0] ref_model(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {(v > 9999), 4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    // Scoreboard: every DONE pulse consumes one queued expectation.
    always @(negedge clk) begin
        logic [16:0] exp_v;
        if (done === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got ovf=%b bcd=%h, required no DONE", overflow, bcd_out);
            end else begin
                exp_v = sb.pop_front();
                if ({overflow, bcd_out} !== exp_v) begin
                    fails++;
                    $display("FAIL result: got ovf=%b bcd=%h, required ovf=%b bcd=%h",
                             overflow, bcd_out, exp_v[16], exp_v[15:0]);
                end
            end
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL busy_with_done: got busy=%b, required 0", busy);
            end
        end
    end

    task automatic start_conv(input int v, input bit push);
        start  = 1'b1;
        bin_in = 14'(v);
        if (push) sb.push_back(ref_model(v));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s_timeout: got no DONE in %0d cycles, required DONE", name, n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, overflow, bcd_out} !== 19'd0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b ovf=%b bcd=%h, required all 0",
                     busy, done, overflow, bcd_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero;
        int n = 0;
        start_conv(0, 1'b1);
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n !== 14) begin
            fails++;
            $display("FAIL zero_latency: got %0d cycles after accept, required 14", n);
        end
    endtask

    task automatic test_latency_1234;
        int n = 0;
        int busy_cycles = 0;
        bit early = 1'b0;
        start_conv(1234, 1'b1);
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_cycles++;
            if (bcd_out !== 16'h0000) early = 1'b1;
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy_cycles !== 14) begin
            fails++;
            $display("FAIL busy_width: got %0d, required 14", busy_cycles);
        end
        tests++;
        if (n !== 14) begin
            fails++;
            $display("FAIL latency_1234: got %0d, required 14", n);
        end
        tests++;
        if (early) begin
            fails++;
            $display("FAIL early_update: got BCD_OUT change before completion, required held 0000");
        end
    endtask

    task automatic test_overflow;
        int vals[3] = '{9999, 16383, 10};
        foreach (vals[i]) begin
            start_conv(vals[i], 1'b1);
            wait_done("overflow");
        end
        repeat (5) @(negedge clk);
        tests++;
        if ({overflow, bcd_out} !== ref_model(10)) begin
            fails++;
            $display("FAIL hold_result: got ovf=%b bcd=%h, required ovf=0 bcd=0010", overflow, bcd_out);
        end
    endtask

    task automatic test_ignored_start;
        int extra = 0;
        start_conv(4321, 1'b1);
        repeat (4) @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd55;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 14'd777;
        wait_done("ignored_start");
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        tests++;
        if (extra !== 0) begin
            fails++;
            $display("FAIL ignored_start: got %0d extra DONE pulses, required 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        start_conv(8765, 1'b0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, done, overflow, bcd_out} !== 19'd0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b done=%b ovf=%b bcd=%h, required all 0",
                     busy, done, overflow, bcd_out);
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        tests++;
        if (pulses !== 0) begin
            fails++;
            $display("FAIL reset_mid_done: got %0d DONE pulses, required 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int vals[$];
        for (int v = 0; v < 400; v++) vals.push_back(v);
        vals.push_back(9998);
        vals.push_back(9999);
        vals.push_back(10000);
        vals.push_back(16383);
        for (int i = 0; i < 100; i++) vals.push_back(int'($urandom_range(16383, 0)));
        start = 1'b1;
        foreach (vals[i]) begin
            bin_in = 14'(vals[i]);
            sb.push_back(ref_model(vals[i]));
            repeat (15) @(negedge clk);
            tests++;
            if (done !== 1'b1) begin
                fails++;
                $display("FAIL b2b_period: value %0d got DONE=%b at 15 cycles, required 1", vals[i], done);
            end
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_zero();
        test_latency_1234();
        test_overflow();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
